// File: rtl/watch_time_dp.sv
// Watch-mode timekeeping datapath: hundredths/seconds/minutes/hours counters
// advanced by a divided 10 ms tick, with per-field up/down adjust strobes.
// Optional feature macro: WATCH_ADJ_CARRY_EN (adjust wraps ripple upward).
// Ports:
//   clk, rst (async, active-low)
//   i_sec_up/i_sec_down, i_min_up/i_min_down, i_hour_up/i_hour_down : adjust strobes
//   o_msec[6:0], o_sec[5:0], o_min[5:0], o_hour[4:0] : registered time fields
//   o_tick : registered one-cycle pulse per tick
module watch_time_dp #(
  parameter int unsigned TICK_DIV  = 1_000_000,
  parameter int unsigned INIT_HOUR = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_sec_up,
  input  logic       i_sec_down,
  input  logic       i_min_up,
  input  logic       i_min_down,
  input  logic       i_hour_up,
  input  logic       i_hour_down,
  output logic [6:0] o_msec,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic       o_tick
);

  localparam int unsigned CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [6:0]  MSEC_MAX = 7'd99;
  localparam logic [5:0]  SEC_MAX  = 6'd59;
  localparam logic [5:0]  MIN_MAX  = 6'd59;
  localparam logic [4:0]  HOUR_MAX = 5'd23;

`ifdef WATCH_ADJ_CARRY_EN
  localparam logic ADJ_CARRY = 1'b1;
`else
  localparam logic ADJ_CARRY = 1'b0;
`endif

  // Modulo step for a 0..max field; inc has priority over dec.
  function automatic logic [5:0] step60(input logic [5:0] v, input logic [5:0] max,
                                        input logic inc, input logic dec);
    if (inc)      return (v == max) ? 6'd0 : 6'(v + 6'd1);
    else if (dec) return (v == 6'd0) ? max : 6'(v - 6'd1);
    else          return v;
  endfunction

  function automatic logic [4:0] step24(input logic [4:0] v, input logic inc, input logic dec);
    if (inc)      return (v == HOUR_MAX) ? 5'd0 : 5'(v + 5'd1);
    else if (dec) return (v == 5'd0) ? HOUR_MAX : 5'(v - 5'd1);
    else          return v;
  endfunction

  logic [CNT_W-1:0] tick_cnt;
  logic             tick_c;
  logic             msec_wrap_c;

  logic sec_up_c, sec_dn_c, sec_adj_c;
  logic min_up_c, min_dn_c, min_adj_c;
  logic hour_up_c, hour_dn_c, hour_adj_c;
  logic sec_inc_c, sec_dec_c, sec_cy_up_c, sec_cy_dn_c;
  logic min_inc_c, min_dec_c, min_cy_up_c, min_cy_dn_c;
  logic hour_inc_c, hour_dec_c;

  logic [6:0] msec_nxt;
  logic [5:0] sec_nxt;
  logic [5:0] min_nxt;
  logic [4:0] hour_nxt;

  assign tick_c      = (tick_cnt == CNT_W'(TICK_DIV - 1));
  assign msec_wrap_c = tick_c && (o_msec == MSEC_MAX);

  // Up wins over down within a field.
  assign sec_up_c   = i_sec_up;
  assign sec_dn_c   = i_sec_down & ~i_sec_up;
  assign sec_adj_c  = i_sec_up | i_sec_down;
  assign min_up_c   = i_min_up;
  assign min_dn_c   = i_min_down & ~i_min_up;
  assign min_adj_c  = i_min_up | i_min_down;
  assign hour_up_c  = i_hour_up;
  assign hour_dn_c  = i_hour_down & ~i_hour_up;
  assign hour_adj_c = i_hour_up | i_hour_down;

  // An adjusted field ignores any incoming carry, which also stops it rippling further.
  assign sec_inc_c   = sec_up_c | (~sec_adj_c & msec_wrap_c);
  assign sec_dec_c   = sec_dn_c;
  assign sec_cy_up_c = sec_adj_c ? (ADJ_CARRY & sec_up_c & (o_sec == SEC_MAX))
                                 : (msec_wrap_c & (o_sec == SEC_MAX));
  assign sec_cy_dn_c = ADJ_CARRY & sec_dn_c & (o_sec == 6'd0);

  assign min_inc_c   = min_up_c | (~min_adj_c & sec_cy_up_c);
  assign min_dec_c   = min_dn_c | (~min_adj_c & sec_cy_dn_c);
  assign min_cy_up_c = min_adj_c ? (ADJ_CARRY & min_up_c & (o_min == MIN_MAX))
                                 : (sec_cy_up_c & (o_min == MIN_MAX));
  assign min_cy_dn_c = min_adj_c ? (ADJ_CARRY & min_dn_c & (o_min == 6'd0))
                                 : (sec_cy_dn_c & (o_min == 6'd0));

  assign hour_inc_c  = hour_up_c | (~hour_adj_c & min_cy_up_c);
  assign hour_dec_c  = hour_dn_c | (~hour_adj_c & min_cy_dn_c);

  // Next-state values for the time fields.
  always_comb begin
    msec_nxt = o_msec;
    if (tick_c) msec_nxt = msec_wrap_c ? 7'd0 : 7'(o_msec + 7'd1);
    sec_nxt  = step60(o_sec, SEC_MAX, sec_inc_c, sec_dec_c);
    min_nxt  = step60(o_min, MIN_MAX, min_inc_c, min_dec_c);
    hour_nxt = step24(o_hour, hour_inc_c, hour_dec_c);
  end

  // Divider and time registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
      o_tick   <= 1'b0;
      o_msec   <= 7'd0;
      o_sec    <= 6'd0;
      o_min    <= 6'd0;
      o_hour   <= 5'(INIT_HOUR);
    end else begin
      tick_cnt <= tick_c ? '0 : CNT_W'(tick_cnt + CNT_W'(1));
      o_tick   <= tick_c;
      o_msec   <= msec_nxt;
      o_sec    <= sec_nxt;
      o_min    <= min_nxt;
      o_hour   <= hour_nxt;
    end
  end

endmodule

// File: tb/tb_watch_time_dp.sv
// Self-checking bench for watch_time_dp with TICK_DIV=4, INIT_HOUR=12.
module tb_watch_time_dp;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_sec_up, i_sec_down, i_min_up, i_min_down, i_hour_up, i_hour_down;
  logic [6:0] o_msec;
  logic [5:0] o_sec;
  logic [5:0] o_min;
  logic [4:0] o_hour;
  logic       o_tick;

  int total = 0;
  int bad   = 0;

  watch_time_dp #(.TICK_DIV(4), .INIT_HOUR(12)) dut (
    .clk(clk), .rst(rst),
    .i_sec_up(i_sec_up), .i_sec_down(i_sec_down),
    .i_min_up(i_min_up), .i_min_down(i_min_down),
    .i_hour_up(i_hour_up), .i_hour_down(i_hour_down),
    .o_msec(o_msec), .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour), .o_tick(o_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] adj;  // {sec_up, sec_down, min_up, min_down, hour_up, hour_down}
    int         hour;
    int         min;
    int         sec;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic chk_time(input string name, input int h, input int m, input int s);
    chk({name, ".hour"}, int'(o_hour), h);
    chk({name, ".min"},  int'(o_min),  m);
    chk({name, ".sec"},  int'(o_sec),  s);
  endtask

  // Strobes applied for exactly one edge; called at posedge+1.
  task automatic apply(input logic [5:0] adj);
    {i_sec_up, i_sec_down, i_min_up, i_min_down, i_hour_up, i_hour_down} = adj;
    @(posedge clk); #1;
    {i_sec_up, i_sec_down, i_min_up, i_min_down, i_hour_up, i_hour_down} = 6'b0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Synchronise on the tick edge where msec reaches 99.
  task automatic wait_msec99(input string name);
    int n;
    n = 0;
    while (o_msec != 7'd99 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, ".msec99_reached"}, int'(o_msec), 99);
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{6'b010000, 12,  0, 59};
    vecs[1]  = '{6'b100000, 12,  0,  0};
    vecs[2]  = '{6'b000100, 12, 59,  0};
    vecs[3]  = '{6'b000001, 11, 59,  0};
    vecs[4]  = '{6'b110000, 11, 59,  1};
    vecs[5]  = '{6'b001001, 10,  0,  1};
    vecs[6]  = '{6'b000011, 11,  0,  1};
    vecs[7]  = '{6'b101010, 12,  1,  2};
    vecs[8]  = '{6'b000000, 12,  1,  2};
    vecs[9]  = '{6'b001100, 12,  2,  2};
    vecs[10] = '{6'b000010, 13,  2,  2};
    vecs[11] = '{6'b000001, 12,  2,  2};

    {i_sec_up, i_sec_down, i_min_up, i_min_down, i_hour_up, i_hour_down} = 6'b0;
    rst = 1'b0;
    step(3);

    chk_time("reset", 12, 0, 0);
    chk("reset.msec", int'(o_msec), 0);
    chk("reset.tick", int'(o_tick), 0);

    rst = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk); #1;
      chk($sformatf("run.tick_e%0d", e), int'(o_tick), (e % 4 == 0) ? 1 : 0);
      chk($sformatf("run.msec_e%0d", e), int'(o_msec), e / 4);
    end

`ifdef WATCH_ADJ_CARRY_EN
    apply(6'b000100);            // min 0->59 borrows: 11:59:00
    apply(6'b000010);            // 12:59:00
    apply(6'b010000);            // sec 0->59 borrows: 12:58:59
    apply(6'b001000);            // 12:59:59
    chk_time("carry.pre", 12, 59, 59);
    apply(6'b100000);
    chk_time("carry.sec_up", 13, 0, 0);
`else
    for (int i = 0; i < 12; i++) begin
      apply(vecs[i].adj);
      chk_time($sformatf("vec%0d", i), vecs[i].hour, vecs[i].min, vecs[i].sec);
    end

    for (int i = 0; i < 12; i++) apply(6'b000001);
    chk("hour_to_zero", int'(o_hour), 0);
    apply(6'b000001);
    chk("hour_0_down", int'(o_hour), 23);

    for (int i = 0; i < 3; i++) apply(6'b000100);
    for (int i = 0; i < 3; i++) apply(6'b010000);
    chk_time("preload", 23, 59, 59);

    // Full rollover on a single tick.
    wait_msec99("roll");
    step(3);
    chk_time("roll.pre", 23, 59, 59);
    chk("roll.pre_tick", int'(o_tick), 0);
    step(1);
    chk_time("roll", 0, 0, 0);
    chk("roll.msec", int'(o_msec), 0);
    chk("roll.tick", int'(o_tick), 1);

    // Tick carry into min dropped in favour of min_up.
    for (int i = 0; i < 5; i++) apply(6'b001000);
    apply(6'b010000);
    chk_time("col1.pre", 0, 5, 59);
    wait_msec99("col1");
    step(3);
    apply(6'b001000);
    chk_time("col1", 0, 6, 0);
    chk("col1.msec", int'(o_msec), 0);
    chk("col1.tick", int'(o_tick), 1);

    // sec_down wins over the tick carry into sec; msec still wraps.
    for (int i = 0; i < 10; i++) apply(6'b100000);
    wait_msec99("col2");
    chk_time("col2.pre", 0, 6, 10);
    step(3);
    apply(6'b010000);
    chk_time("col2", 0, 6, 9);
    chk("col2.msec", int'(o_msec), 0);
`endif

    // Asynchronous reset between edges.
    apply(6'b100000);
    #2 rst = 1'b0;
    #1;
    chk_time("async_rst", 12, 0, 0);
    chk("async_rst.msec", int'(o_msec), 0);
    chk("async_rst.tick", int'(o_tick), 0);
    step(1);
    rst = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/watch_time_dp.md
# watch_time_dp

Timekeeping datapath for the watch mode; it consumes the one-cycle adjust strobes from the watch control unit. It holds hundredths, seconds, minutes and hours counters, advances them from a divided clock tick, and applies sec/min/hour up/down adjustments. Its registered time fields feed the FND display formatter.

## Interface
- `TICK_DIV`, default 1_000_000: clk cycles per 10 ms tick (100 MHz clk). Legal range is ≥2.
- `INIT_HOUR`, default 12: hour value loaded at reset. Legal range is 0–23.
- `clk` in 1: system clock. All state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `i_sec_up` / `i_sec_down` in 1 each: one-cycle strobes that adjust seconds.
- `i_min_up` / `i_min_down` in 1 each: one-cycle strobes that adjust minutes.
- `i_hour_up` / `i_hour_down` in 1 each: one-cycle strobes that adjust hours.
- `o_msec` out 7: hundredths of a second, 0–99.
- `o_sec` out 6: seconds, 0–59.
- `o_min` out 6: minutes, 0–59.
- `o_hour` out 5: hours, 0–23.
- `o_tick` out 1: one-cycle pulse on every 10 ms tick.

## Operation
- **Tick divider**
  - `tick_cnt` counts 0..`TICK_DIV`-1 and then wraps to 0.
  - The internal tick is asserted combinationally while `tick_cnt == TICK_DIV-1`.
  - `o_tick` is that tick, registered.
- **Free-run chain** (on a tick cycle):
  - `msec` increments and wraps 99→0.
  - The 99→0 wrap carries into `sec` (59→0).
  - The `sec` wrap carries into `min` (59→0).
  - The `min` wrap carries into `hour` (23→0).
  - Each carry is gated by all lower fields being at their maximum in that same cycle.
- **Adjust**
  - `*_up` adds 1 to its field modulo the field range. `*_down` subtracts 1 modulo the range: 0→59 for sec/min, 0→23 for hour.
  - If both up and down are asserted for the same field, up wins and down is ignored.
  - Different fields may be adjusted in the same cycle; each is applied independently.
- **Adjust vs tick collision**
  - An adjust on a field takes priority over any tick carry into that field in the same cycle. That carry is dropped; it does not propagate further.
  - Lower fields still advance normally from the tick.
  - `msec` is never affected by adjust strobes.
- A strobe held high for N cycles applies N adjustments. Level-to-pulse conversion is the control unit's job.
- Width rule: every field compare and wrap uses its exact range constant. Counters never leave their legal range.

## Timing
- **Reset** (`rst` low, asynchronous):
  - `tick_cnt` = 0, `o_msec` = 0, `o_sec` = 0, `o_min` = 0, `o_hour` = `INIT_HOUR`, `o_tick` = 0.
  - Reset asserted mid-count or mid-adjust discards all state immediately.
- First tick: after `rst` deasserts, the first tick occurs on the `TICK_DIV`-th rising edge. `o_msec` = 1 and `o_tick` = 1 appear after that edge.
- **Latency**
  - Adjust strobe sampled at edge k → field shows the new value after edge k (1 cycle).
  - Tick-driven change → visible after the same edge at which `o_tick` rises.
- `o_tick` is high for exactly one cycle per `TICK_DIV` cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- **`WATCH_ADJ_CARRY_EN` defined:** adjustments ripple into the next field.
  - `sec` up 59→0 also increments `min`; `sec` down 0→59 also decrements `min`.
  - `min` up/down wrapping similarly increments/decrements `hour`, with hour wrap 23↔0.
  - `hour` wrap never carries.
  - This carry follows the same collision rule: an explicit adjust on the upper field in the same cycle overrides it.
- **Undefined (default):** each field wraps in isolation on adjust. Only tick-driven carries propagate.

## Test plan
- **Reset:** `TICK_DIV`=4, hold `rst`=0 → outputs 12:00:00.00 and `o_tick`=0. Release → `o_tick` pulses on every 4th cycle and `o_msec` reads 1, 2, 3…
- **Full rollover:** preload via adjusts to 23:59:59, then let `msec` reach 99; one tick → 00:00:00.00 in a single cycle.
- **Adjust wrap (macro off):**
  - `sec`=59 + `i_sec_up` → `sec`=0 and `min` unchanged.
  - `hour`=0 + `i_hour_down` → `hour`=23.
  - `min`=0 + `i_min_down` → 59.
- **Collision:**
  - At 00:05:59.99, tick together with `i_min_up` → 00:06:00.00 (the carry is dropped and the adjust applies).
  - Tick together with `i_sec_down` at `sec`=10, `msec`=99 → `sec`=9, `msec`=0.
- **Priority and multi-field:**
  - `i_sec_up` and `i_sec_down` together → +1 only.
  - `i_min_up` and `i_hour_down` together → both applied in the same cycle.
- **Macro on / async reset:**
  - With `WATCH_ADJ_CARRY_EN`, 12:59:59 + `i_sec_up` → 13:00:00.
  - Assert `rst` mid-cycle → outputs return to 12:00:00.00 before the next edge.
